// File: rtl/stage_two_requant.sv
// Stage-two requantizer: walks the stage-one accumulator buffer after a start pulse and
// writes scaled, rounded, optionally rectified and saturated OUT_W-bit results.
module stage_two_requant #(
    parameter int ACC_W  = 32,
    parameter int MULT_W = 16,
    parameter int OUT_W  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        row_shape,
    input  logic [7:0]        col_shape,
    input  logic [MULT_W-1:0] mult,
    input  logic [5:0]        shift,
    input  logic              relu_en,
    output logic              busy,
    output logic              done,
    output logic              acc_rd_en,
    output logic [ADDR_W-1:0] acc_rd_addr,
    input  logic [ACC_W-1:0]  acc_rd_data,
    output logic              out_wr_en,
    output logic [ADDR_W-1:0] out_wr_addr,
    output logic [OUT_W-1:0]  out_wr_data
);

    localparam int PW = ACC_W + MULT_W + 1;
    // One guard bit so adding the rounding bias can never overflow.
    localparam int RW = PW + 1;
    localparam logic signed [RW-1:0] SAT_MAX = RW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [RW-1:0] SAT_MIN = -SAT_MAX - RW'(1);
    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [ADDR_W-1:0] n_last_reg;
    logic [MULT_W-1:0] mult_reg;
    logic [5:0]        shift_reg;
    logic              relu_reg;

    logic              rd_en_reg;
    logic [ADDR_W-1:0] rd_addr_reg;
    logic              vld0_reg, vld1_reg;
    logic [ADDR_W-1:0] addr0_reg, addr1_reg;
    logic signed [PW-1:0] p_reg;
    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [OUT_W-1:0]  wr_data_reg;

    logic [15:0]          n_prod;
    logic [ADDR_W-1:0]    n_start;
    logic signed [PW-1:0] p_next;
    logic signed [RW-1:0] bias, rounded, relu_v;
    logic [OUT_W-1:0]     result;

    assign n_prod  = 16'(row_shape) * 16'(col_shape);
    assign n_start = ADDR_W'(n_prod);
    assign p_next  = PW'($signed(acc_rd_data)) * PW'($signed({1'b0, mult_reg}));

    always_comb begin
        bias = '0;
        if (shift_reg != 6'd0) begin
            bias = RW'(1) <<< (shift_reg - 6'd1);
        end
        rounded = (RW'(p_reg) + bias) >>> shift_reg;
        relu_v  = rounded;
        if (relu_reg && rounded[RW-1]) begin
            relu_v = '0;
        end
        if (relu_v > SAT_MAX) begin
            result = OUT_MAX;
        end else if (relu_v < SAT_MIN) begin
            result = OUT_MIN;
        end else begin
            result = relu_v[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = (n_start == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (rd_addr_reg == n_last_reg) state_next = ST_DRAIN;
            ST_DRAIN: if (wr_en_reg && wr_addr_reg == n_last_reg) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_last_reg  <= '0;
            mult_reg    <= '0;
            shift_reg   <= '0;
            relu_reg    <= 1'b0;
            rd_en_reg   <= 1'b0;
            rd_addr_reg <= '0;
            vld0_reg    <= 1'b0;
            vld1_reg    <= 1'b0;
            addr0_reg   <= '0;
            addr1_reg   <= '0;
            p_reg       <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            // Stage 0 tracks the read whose data is on acc_rd_data this cycle.
            vld0_reg  <= rd_en_reg;
            addr0_reg <= rd_addr_reg;
            vld1_reg  <= vld0_reg;
            addr1_reg <= addr0_reg;
            if (vld0_reg) begin
                p_reg <= p_next;
            end
            wr_en_reg <= vld1_reg;
            if (vld1_reg) begin
                wr_addr_reg <= addr1_reg;
                wr_data_reg <= result;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        n_last_reg  <= n_start - ADDR_W'(1);
                        mult_reg    <= mult;
                        shift_reg   <= shift;
                        relu_reg    <= relu_en;
                        rd_en_reg   <= (n_start != '0);
                        rd_addr_reg <= '0;
                    end
                end
                ST_RUN: begin
                    if (rd_addr_reg == n_last_reg) begin
                        rd_en_reg   <= 1'b0;
                        rd_addr_reg <= '0;
                    end else begin
                        rd_addr_reg <= rd_addr_reg + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign done        = (state_reg == ST_DONE);
    assign acc_rd_en   = rd_en_reg;
    assign acc_rd_addr = rd_addr_reg;
    assign out_wr_en   = wr_en_reg;
    assign out_wr_addr = wr_addr_reg;
    assign out_wr_data = wr_data_reg;

endmodule

// File: tb/tb_stage_two_requant.sv
// Directed bench for stage_two_requant: accumulator buffer model, per-job cycle
// bookkeeping relative to the accepting edge, and hand-computed expected results.
module tb_stage_two_requant;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  row_shape, col_shape;
    logic [15:0] mult;
    logic [5:0]  shift;
    logic        relu_en;
    logic        busy, done;
    logic        acc_rd_en;
    logic [15:0] acc_rd_addr;
    logic [31:0] acc_rd_data = '0;
    logic        out_wr_en;
    logic [15:0] out_wr_addr;
    logic [7:0]  out_wr_data;

    int total = 0;
    int bad   = 0;

    logic signed [31:0] acc_mem [64];

    int n_rd, first_rd, last_rd, rd_seq_err;
    int n_wr, first_wr, last_wr, wr_seq_err;
    int done_cyc, done_cnt, busy_cnt, rst_leak;
    int wr_data [64];

    always #5 clk = ~clk;

    stage_two_requant dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .row_shape  (row_shape),
        .col_shape  (col_shape),
        .mult       (mult),
        .shift      (shift),
        .relu_en    (relu_en),
        .busy       (busy),
        .done       (done),
        .acc_rd_en  (acc_rd_en),
        .acc_rd_addr(acc_rd_addr),
        .acc_rd_data(acc_rd_data),
        .out_wr_en  (out_wr_en),
        .out_wr_addr(out_wr_addr),
        .out_wr_data(out_wr_data)
    );

    // Registered-read accumulator buffer: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (acc_rd_en) acc_rd_data <= acc_mem[acc_rd_addr[5:0]];
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Cycle k of the job is the k-th cycle after the edge that accepts start.
    task automatic run_job(input int rows, input int cols, input int m, input int s,
                           input int relu, input int budget, input int repulse_at,
                           input int rst_at);
        n_rd = 0; first_rd = -1; last_rd = -1; rd_seq_err = 0;
        n_wr = 0; first_wr = -1; last_wr = -1; wr_seq_err = 0;
        done_cyc = -1; done_cnt = 0; busy_cnt = 0; rst_leak = 0;
        for (int i = 0; i < 64; i++) wr_data[i] = 999;
        @(negedge clk);
        row_shape = 8'(rows); col_shape = 8'(cols);
        mult = 16'(m); shift = 6'(s); relu_en = (relu != 0);
        start = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                row_shape = 8'hA5; col_shape = 8'h3C;
                mult = 16'h7777; shift = 6'd33; relu_en = !relu_en;
            end
            if (acc_rd_en) begin
                if (int'(acc_rd_addr) != n_rd) rd_seq_err++;
                if (n_rd == 0) first_rd = k;
                last_rd = k;
                n_rd++;
            end
            if (out_wr_en) begin
                if (int'(out_wr_addr) != n_wr) wr_seq_err++;
                if (n_wr == 0) first_wr = k;
                last_wr = k;
                n_wr++;
                wr_data[out_wr_addr[5:0]] = int'($signed(out_wr_data));
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (busy) busy_cnt++;
            if (rst_at > 0 && k == rst_at + 1) begin
                rst_leak = int'(acc_rd_en | out_wr_en | busy | done);
                rst = 1'b0;
            end
            if (rst_at > 0 && k == rst_at) rst = 1'b1;
            if (repulse_at > 0 && k == repulse_at + 1) start = 1'b0;
            if (repulse_at > 0 && k == repulse_at) start = 1'b1;
        end
        $display("job %0dx%0d mult=%0d shift=%0d relu=%0d: reads=%0d writes=%0d done@%0d",
                 rows, cols, m, s, relu, n_rd, n_wr, done_cyc);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; row_shape = '0; col_shape = '0;
        mult = '0; shift = '0; relu_en = 1'b0;
        for (int i = 0; i < 64; i++) acc_mem[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", acc_rd_en, 0);
        chk("rst_rd_addr", acc_rd_addr, 0);
        chk("rst_wr_en", out_wr_en, 0);
        rst = 1'b0;

        // 4x12 identity job
        for (int i = 0; i < 48; i++) acc_mem[i] = i;
        run_job(4, 12, 1, 0, 0, 56, 0, 0);
        chk("lin_nrd", n_rd, 48);
        chk("lin_first_rd", first_rd, 1);
        chk("lin_last_rd", last_rd, 48);
        chk("lin_rd_seq", rd_seq_err, 0);
        chk("lin_nwr", n_wr, 48);
        chk("lin_first_wr", first_wr, 4);
        chk("lin_last_wr", last_wr, 51);
        chk("lin_wr_seq", wr_seq_err, 0);
        chk("lin_done_cyc", done_cyc, 52);
        chk("lin_done_cnt", done_cnt, 1);
        chk("lin_busy_cnt", busy_cnt, 51);
        for (int i = 0; i < 48; i++) chk($sformatf("lin_d%0d", i), wr_data[i], i);

        // saturation, no ReLU
        acc_mem[0] = 300; acc_mem[1] = -300; acc_mem[2] = -5; acc_mem[3] = 5;
        run_job(1, 4, 1, 0, 0, 12, 0, 0);
        chk("sat_pos", wr_data[0], 127);
        chk("sat_neg", wr_data[1], -128);
        chk("neg_norelu", wr_data[2], -5);
        chk("pos_small", wr_data[3], 5);
        chk("sat_done_cyc", done_cyc, 8);

        // ReLU
        acc_mem[0] = -5; acc_mem[1] = 300; acc_mem[2] = -300; acc_mem[3] = 7;
        run_job(2, 2, 1, 0, 1, 12, 0, 0);
        chk("relu_m5", wr_data[0], 0);
        chk("relu_300", wr_data[1], 127);
        chk("relu_m300", wr_data[2], 0);
        chk("relu_7", wr_data[3], 7);

        // rounding, shift=1
        acc_mem[0] = 3; acc_mem[1] = -3; acc_mem[2] = 2; acc_mem[3] = -2; acc_mem[4] = 1;
        run_job(1, 5, 1, 1, 0, 14, 0, 0);
        chk("rnd_3", wr_data[0], 2);
        chk("rnd_m3", wr_data[1], -1);
        chk("rnd_2", wr_data[2], 1);
        chk("rnd_m2", wr_data[3], -1);
        chk("rnd_1", wr_data[4], 1);

        // scaling mult=16384 shift=15
        acc_mem[0] = 200; acc_mem[1] = -200; acc_mem[2] = 1000;
        run_job(1, 3, 16384, 15, 0, 12, 0, 0);
        chk("scl_200", wr_data[0], 100);
        chk("scl_m200", wr_data[1], -100);
        chk("scl_1000", wr_data[2], 127);

        // zero shape
        run_job(0, 12, 1, 0, 0, 6, 0, 0);
        chk("zero_nrd", n_rd, 0);
        chk("zero_nwr", n_wr, 0);
        chk("zero_done_cyc", done_cyc, 1);
        chk("zero_done_cnt", done_cnt, 1);
        chk("zero_busy_cnt", busy_cnt, 0);

        // start re-pulsed during RUN
        for (int i = 0; i < 48; i++) acc_mem[i] = i;
        run_job(4, 12, 1, 0, 0, 56, 10, 0);
        chk("rep_nrd", n_rd, 48);
        chk("rep_nwr", n_wr, 48);
        chk("rep_done_cyc", done_cyc, 52);
        chk("rep_done_cnt", done_cnt, 1);

        // reset mid-job, then a fresh job
        run_job(4, 12, 1, 0, 0, 40, 0, 20);
        chk("mrst_leak", rst_leak, 0);
        chk("mrst_done_cnt", done_cnt, 0);
        chk("mrst_nrd", n_rd, 20);
        chk("mrst_nwr", n_wr, 17);
        run_job(4, 12, 1, 0, 0, 56, 0, 0);
        chk("fresh_nwr", n_wr, 48);
        chk("fresh_done_cyc", done_cyc, 52);
        chk("fresh_d0", wr_data[0], 0);
        chk("fresh_d47", wr_data[47], 47);

        // back-to-back 1x1 jobs
        acc_mem[0] = -77;
        run_job(1, 1, 1, 0, 0, 5, 0, 0);
        chk("b2b1_done_cyc", done_cyc, 5);
        chk("b2b1_d0", wr_data[0], -77);
        acc_mem[0] = 42;
        run_job(1, 1, 2, 0, 0, 8, 0, 0);
        chk("b2b2_done_cyc", done_cyc, 5);
        chk("b2b2_first_wr", first_wr, 4);
        chk("b2b2_d0", wr_data[0], 84);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
